// File: rtl/memory_bus_pkg.sv
// Shared MemoryBus definitions: default field widths, the request bundle type,
// and the helper that extracts the owning port index from a transaction ID.
package memory_bus_pkg;

  localparam int DEF_ID_WIDTH      = 8;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 24;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]      id;
    logic [DEF_ADDRESS_WIDTH-1:0] address;
    logic [DEF_DATA_WIDTH-1:0]    data;
    logic                         write;
  } mbus_req_t;

  // Owner index lives in the top port_bits of an id_w-bit ID.
  function automatic int owner_of(input logic [31:0] id, input int id_w, input int port_bits);
    logic [31:0] mask;
    mask = (32'd1 << port_bits) - 32'd1;
    return int'((id >> (id_w - port_bits)) & mask);
  endfunction

endpackage

// File: rtl/memory_bus_rr_arbiter_rr_select.sv
// Rotating-priority picker: first set bit of req at or after ptr, wrapping modulo N.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned j;

  // Walk from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        idx = W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_rr_arbiter.sv
// Round-robin arbiter sharing one MemoryBus master among NUM_PORTS requesters,
// with grant locking, ID-routed responses and per-port read throttling.
module memory_bus_rr_arbiter
  import memory_bus_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int MASTER_ID_WIDTH = DEF_ID_WIDTH,
  parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MASTER_ID_WIDTH-1:0] s_msID      [NUM_PORTS],
  input  logic [ADDRESS_WIDTH-1:0]   s_msAddress [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0]      s_msData    [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]       s_msWrite,
  input  logic [NUM_PORTS-1:0]       s_msValid,
  output logic [NUM_PORTS-1:0]       s_msTaken,
  output logic [MASTER_ID_WIDTH-1:0] s_smID      [NUM_PORTS],
  output logic [DATA_WIDTH-1:0]      s_smData    [NUM_PORTS],
  output logic [NUM_PORTS-1:0]       s_smValid,
  input  logic [NUM_PORTS-1:0]       s_smTaken,
  output logic [MASTER_ID_WIDTH-1:0] m_msID,
  output logic [ADDRESS_WIDTH-1:0]   m_msAddress,
  output logic [DATA_WIDTH-1:0]      m_msData,
  output logic                       m_msWrite,
  output logic                       m_msValid,
  input  logic                       m_msTaken,
  input  logic [MASTER_ID_WIDTH-1:0] m_smID,
  input  logic [DATA_WIDTH-1:0]      m_smData,
  input  logic                       m_smValid,
  output logic                       m_smTaken,
  output logic                       err_unrouted,
  output logic                       err_underflow
);

  localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [MASTER_ID_WIDTH-1:0] id;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]      data;
    logic                       write;
  } req_t;

  logic [PORT_BITS-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic                 locked_q, locked_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic                 err_unrouted_q, err_unrouted_d;
  logic                 err_underflow_q, err_underflow_d;

  logic [NUM_PORTS-1:0] eligible, rd_acc, rsp_acc;
  logic [PORT_BITS-1:0] pick, sel;
  logic                 pick_any, sel_elig, routed;
  req_t                 sel_req;
  int                   owner;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = s_msValid[p] && !(!s_msWrite[p] && cnt_q[p] == CNT_MAX);
    end
  end

  rr_select #(.N(NUM_PORTS), .W(PORT_BITS)) u_rr_select (
    .req (eligible),
    .ptr (rr_ptr_q),
    .idx (pick),
    .any (pick_any)
  );

  // A locked grant overrides the picker so the presented request stays stable.
  always_comb begin
    sel      = locked_q ? grant_q : pick;
    sel_elig = 1'b0;
    sel_req  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel == PORT_BITS'(p)) begin
        sel_elig = eligible[p];
        sel_req  = '{id: s_msID[p], address: s_msAddress[p], data: s_msData[p], write: s_msWrite[p]};
      end
    end
    m_msValid   = locked_q ? sel_elig : pick_any;
    m_msID      = sel_req.id;
    m_msAddress = sel_req.address;
    m_msData    = sel_req.data;
    m_msWrite   = sel_req.write;
    for (int p = 0; p < NUM_PORTS; p++) begin
      s_msTaken[p] = m_msTaken && m_msValid && (sel == PORT_BITS'(p));
      rd_acc[p]    = s_msTaken[p] && !s_msWrite[p];
    end
  end

  // Responses with an owner beyond the port range are consumed and dropped.
  always_comb begin
    owner     = owner_of(32'(m_smID), MASTER_ID_WIDTH, PORT_BITS);
    routed    = owner < NUM_PORTS;
    m_smTaken = routed ? 1'b0 : m_smValid;
    for (int p = 0; p < NUM_PORTS; p++) begin
      s_smID[p]    = m_smID;
      s_smData[p]  = m_smData;
      s_smValid[p] = m_smValid && routed && (owner == p);
      if (routed && owner == p) m_smTaken = s_smTaken[p];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_acc[p] = s_smValid[p] && s_smTaken[p];
    end
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    locked_d        = 1'b0;
    err_unrouted_d  = err_unrouted_q || (m_smValid && !routed);
    err_underflow_d = err_underflow_q;
    if (m_msValid && !m_msTaken) begin
      locked_d = 1'b1;
      grant_d  = sel;
    end else if (m_msValid && m_msTaken) begin
      rr_ptr_d = (sel == PORT_BITS'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (rd_acc[p] && !rsp_acc[p]) begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end else if (rsp_acc[p] && !rd_acc[p]) begin
        if (cnt_q[p] == '0) err_underflow_d = 1'b1;
        else                cnt_d[p] = cnt_q[p] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      locked_q        <= 1'b0;
      err_unrouted_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      locked_q        <= locked_d;
      err_unrouted_q  <= err_unrouted_d;
      err_underflow_q <= err_underflow_d;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign err_unrouted  = err_unrouted_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_memory_bus_rr_arbiter.sv
// Scenario bench for memory_bus_rr_arbiter: a 4-port instance for arbitration,
// throttling and response routing, plus a 3-port instance for unrouted IDs.
module tb_memory_bus_rr_arbiter;

  localparam int NP = 4, IDW = 8, AW = 32, DW = 24, MO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [IDW-1:0] s_msID [NP];
  logic [AW-1:0]  s_msAddress [NP];
  logic [DW-1:0]  s_msData [NP];
  logic [NP-1:0]  s_msWrite, s_msValid, s_msTaken, s_smValid, s_smTaken;
  logic [IDW-1:0] s_smID [NP];
  logic [DW-1:0]  s_smData [NP];
  logic [IDW-1:0] m_msID, m_smID;
  logic [AW-1:0]  m_msAddress;
  logic [DW-1:0]  m_msData, m_smData;
  logic           m_msWrite, m_msValid, m_msTaken, m_smValid, m_smTaken;
  logic           err_unrouted, err_underflow;

  logic [IDW-1:0] t_msID [3];
  logic [AW-1:0]  t_msAddress [3];
  logic [DW-1:0]  t_msData [3];
  logic [2:0]     t_msWrite, t_msValid, t_msTaken, t_smValid, t_smTaken;
  logic [IDW-1:0] t_smID [3];
  logic [DW-1:0]  t_smData [3];
  logic [IDW-1:0] tm_msID, tm_smID;
  logic [AW-1:0]  tm_msAddress;
  logic [DW-1:0]  tm_msData, tm_smData;
  logic           tm_msWrite, tm_msValid, tm_msTaken, tm_smValid, tm_smTaken;
  logic           t_err_unrouted, t_err_underflow;

  memory_bus_rr_arbiter #(.NUM_PORTS(NP), .MASTER_ID_WIDTH(IDW), .ADDRESS_WIDTH(AW),
                          .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_msID(s_msID), .s_msAddress(s_msAddress), .s_msData(s_msData), .s_msWrite(s_msWrite),
    .s_msValid(s_msValid), .s_msTaken(s_msTaken), .s_smID(s_smID), .s_smData(s_smData),
    .s_smValid(s_smValid), .s_smTaken(s_smTaken),
    .m_msID(m_msID), .m_msAddress(m_msAddress), .m_msData(m_msData), .m_msWrite(m_msWrite),
    .m_msValid(m_msValid), .m_msTaken(m_msTaken), .m_smID(m_smID), .m_smData(m_smData),
    .m_smValid(m_smValid), .m_smTaken(m_smTaken),
    .err_unrouted(err_unrouted), .err_underflow(err_underflow));

  memory_bus_rr_arbiter #(.NUM_PORTS(3), .MASTER_ID_WIDTH(IDW), .ADDRESS_WIDTH(AW),
                          .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_msID(t_msID), .s_msAddress(t_msAddress), .s_msData(t_msData), .s_msWrite(t_msWrite),
    .s_msValid(t_msValid), .s_msTaken(t_msTaken), .s_smID(t_smID), .s_smData(t_smData),
    .s_smValid(t_smValid), .s_smTaken(t_smTaken),
    .m_msID(tm_msID), .m_msAddress(tm_msAddress), .m_msData(tm_msData), .m_msWrite(tm_msWrite),
    .m_msValid(tm_msValid), .m_msTaken(tm_msTaken), .m_smID(tm_smID), .m_smData(tm_smData),
    .m_smValid(tm_smValid), .m_smTaken(tm_smTaken),
    .err_unrouted(t_err_unrouted), .err_underflow(t_err_underflow));

  int n_vec = 0;
  int n_bad = 0;
  int exp_q [$];

  function automatic logic [AW-1:0] addr_of(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h100;
  endfunction

  function automatic logic [IDW-1:0] id_of(input int p);
    return IDW'((p << 6) | 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_msValid = '0; s_msWrite = '0; m_msTaken = 1'b0;
    m_smValid = 1'b0; m_smID = '0; m_smData = '0; s_smTaken = '0;
    t_msValid = '0; t_msWrite = '0; tm_msTaken = 1'b0;
    tm_smValid = 1'b0; tm_smID = '0; tm_smData = '0; t_smTaken = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    n_vec++; if (m_msValid !== 1'b0) begin n_bad++; $display("FAIL reset_m_msValid got %b want 0", m_msValid); end
    n_vec++; if (s_msTaken !== 4'b0) begin n_bad++; $display("FAIL reset_s_msTaken got %b want 0000", s_msTaken); end
    n_vec++; if (s_smValid !== 4'b0) begin n_bad++; $display("FAIL reset_s_smValid got %b want 0000", s_smValid); end
    n_vec++; if (m_smTaken !== 1'b0) begin n_bad++; $display("FAIL reset_m_smTaken got %b want 0", m_smTaken); end
    n_vec++; if ({err_unrouted, err_underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_errs got %b want 00", {err_unrouted, err_underflow}); end
    tm_smValid = 1'b1; tm_smID = 8'hC0;
    #1;
    n_vec++; if (tm_smTaken !== 1'b1) begin n_bad++; $display("FAIL reset_unrouted_drop got %b want 1", tm_smTaken); end
    idle();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_rr_sweep();
    int e;
    do_reset();
    s_msValid = 4'hF; m_msTaken = 1'b1;
    exp_q = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      #3;
      e = exp_q.pop_front();
      n_vec++; if (s_msTaken !== (4'b1 << e)) begin n_bad++; $display("FAIL sweep_taken[%0d] got %b want %b", k, s_msTaken, 4'b1 << e); end
      n_vec++; if (m_msAddress !== addr_of(e) || m_msID !== id_of(e)) begin n_bad++; $display("FAIL sweep_fields[%0d] got %h/%h want %h/%h", k, m_msAddress, m_msID, addr_of(e), id_of(e)); end
      step();
    end
    idle();
  endtask

  task automatic test_lock();
    int e;
    do_reset();
    exp_q = '{2, 2, 2};
    for (int k = 0; k < 3; k++) begin
      s_msValid = (k == 0) ? 4'b0100 : 4'b0101;
      #3;
      e = exp_q.pop_front();
      n_vec++; if (m_msValid !== 1'b1 || m_msAddress !== addr_of(e)) begin n_bad++; $display("FAIL lock_hold[%0d] got %b/%h want 1/%h", k, m_msValid, m_msAddress, addr_of(e)); end
      step();
    end
    m_msTaken = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(0);
    for (int k = 0; k < 2; k++) begin
      #3;
      e = exp_q.pop_front();
      n_vec++; if (s_msTaken !== (4'b1 << e)) begin n_bad++; $display("FAIL lock_release[%0d] got %b want %b", k, s_msTaken, 4'b1 << e); end
      step();
    end
    idle();
  endtask

  task automatic test_throttle();
    do_reset();
    s_msValid = 4'b0010; m_msTaken = 1'b1;
    for (int k = 0; k < MO; k++) begin
      #3;
      n_vec++; if (s_msTaken !== 4'b0010) begin n_bad++; $display("FAIL throttle_read[%0d] got %b want 0010", k, s_msTaken); end
      step();
    end
    #3;
    n_vec++; if (m_msValid !== 1'b0 || s_msTaken !== 4'b0) begin n_bad++; $display("FAIL throttle_block got %b/%b want 0/0000", m_msValid, s_msTaken); end
    step();
    s_msWrite = 4'b0010;
    #3;
    n_vec++; if (s_msTaken !== 4'b0010) begin n_bad++; $display("FAIL throttle_write got %b want 0010", s_msTaken); end
    step();
    s_msWrite = 4'b0; m_smValid = 1'b1; m_smID = 8'h40; s_smTaken = 4'b0010;
    #3;
    n_vec++; if (s_smValid !== 4'b0010 || m_smTaken !== 1'b1) begin n_bad++; $display("FAIL throttle_resp got %b/%b want 0010/1", s_smValid, m_smTaken); end
    n_vec++; if (m_msValid !== 1'b0) begin n_bad++; $display("FAIL throttle_still_full got %b want 0", m_msValid); end
    step();
    m_smValid = 1'b0; s_smTaken = 4'b0;
    #3;
    n_vec++; if (s_msTaken !== 4'b0010) begin n_bad++; $display("FAIL throttle_regrant got %b want 0010", s_msTaken); end
    step();
    #3;
    n_vec++; if (m_msValid !== 1'b0 || err_underflow !== 1'b0) begin n_bad++; $display("FAIL throttle_refull got %b/%b want 0/0", m_msValid, err_underflow); end
    idle();
  endtask

  task automatic test_resp_hold();
    do_reset();
    m_smValid = 1'b1; m_smID = 8'h80; m_smData = 24'hABCDEF; s_smTaken = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      #3;
      n_vec++; if (s_smValid !== 4'b0100 || m_smTaken !== 1'b0) begin n_bad++; $display("FAIL resp_wait[%0d] got %b/%b want 0100/0", k, s_smValid, m_smTaken); end
      n_vec++; if (s_smData[3] !== 24'hABCDEF || s_smID[0] !== 8'h80) begin n_bad++; $display("FAIL resp_bcast[%0d] got %h/%h want abcdef/80", k, s_smData[3], s_smID[0]); end
      step();
    end
    s_smTaken = 4'b0100;
    #3;
    n_vec++; if (m_smTaken !== 1'b1) begin n_bad++; $display("FAIL resp_take got %b want 1", m_smTaken); end
    step();
    idle();
    #3;
    n_vec++; if (err_underflow !== 1'b1 || err_unrouted !== 1'b0) begin n_bad++; $display("FAIL resp_underflow got %b/%b want 1/0", err_underflow, err_unrouted); end
  endtask

  task automatic test_unrouted();
    do_reset();
    tm_smValid = 1'b1; tm_smID = 8'h80; t_smTaken = 3'b000;
    #3;
    n_vec++; if (t_smValid !== 3'b100 || tm_smTaken !== 1'b0) begin n_bad++; $display("FAIL unr_routed got %b/%b want 100/0", t_smValid, tm_smTaken); end
    step();
    tm_smID = 8'hC0; t_smTaken = 3'b111;
    #3;
    n_vec++; if (tm_smTaken !== 1'b1 || t_smValid !== 3'b000) begin n_bad++; $display("FAIL unr_drop got %b/%b want 1/000", tm_smTaken, t_smValid); end
    n_vec++; if (t_err_unrouted !== 1'b0) begin n_bad++; $display("FAIL unr_flag_early got %b want 0", t_err_unrouted); end
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      #3;
      n_vec++; if (t_err_unrouted !== 1'b1) begin n_bad++; $display("FAIL unr_flag[%0d] got %b want 1", k, t_err_unrouted); end
      step();
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    s_msValid = 4'b0010; m_msTaken = 1'b1;
    step();
    s_msValid = 4'b1001; m_msTaken = 1'b0;
    #3;
    n_vec++; if (m_msAddress !== addr_of(3)) begin n_bad++; $display("FAIL midlock_pick got %h want %h", m_msAddress, addr_of(3)); end
    step();
    #3;
    n_vec++; if (m_msAddress !== addr_of(3)) begin n_bad++; $display("FAIL midlock_held got %h want %h", m_msAddress, addr_of(3)); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (m_msAddress !== addr_of(0) || s_msTaken !== 4'b0) begin n_bad++; $display("FAIL midlock_cleared got %h/%b want %h/0000", m_msAddress, s_msTaken, addr_of(0)); end
    step();
    step();
    rst_n = 1'b1; m_msTaken = 1'b1;
    #3;
    n_vec++; if (s_msTaken !== 4'b0001) begin n_bad++; $display("FAIL midlock_first got %b want 0001", s_msTaken); end
    step();
    idle();
    m_smValid = 1'b1; m_smID = 8'h40; s_smTaken = 4'b0010;
    #3;
    n_vec++; if (m_smTaken !== 1'b1) begin n_bad++; $display("FAIL midlock_resp got %b want 1", m_smTaken); end
    step();
    idle();
    #3;
    n_vec++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL midlock_cnt_zero got %b want 1", err_underflow); end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      s_msID[p] = id_of(p); s_msAddress[p] = addr_of(p); s_msData[p] = DW'(p * 3 + 1);
    end
    for (int p = 0; p < 3; p++) begin
      t_msID[p] = id_of(p); t_msAddress[p] = addr_of(p); t_msData[p] = DW'(p);
    end
    rst_n = 1'b0;
    idle();
    step();
    test_reset();
    test_rr_sweep();
    test_lock();
    test_throttle();
    test_resp_hold();
    test_unrouted();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_rr_arbiter.md
Name: memory_bus_rr_arbiter

Overview:
- N-port round-robin arbiter that shares one downstream MemoryBus master port among NUM_PORTS upstream requesters.
- Grant is locked from first presentation until the transfer completes, so mbus request fields never change while msValid is high and msTaken is low.
- Responses return to the owning port, decoded from the upper PORT_BITS of smID.
- Per-port outstanding-read counters throttle any requester that reaches MAX_OUTSTANDING.
- Sits between client engines (rasteriser, frame reader, etc.) and the memory controller. It replaces the chains of two-input arbiters.

Parameters:
- NUM_PORTS, 4, number of upstream requesters (2..8).
- MASTER_ID_WIDTH, 8, width of msID/smID.
- ADDRESS_WIDTH, 32, request address width.
- DATA_WIDTH, 24, request/response data width.
- MAX_OUTSTANDING, 4, maximum unanswered reads per port (1..15).
- PORT_BITS, $clog2(NUM_PORTS), derived localparam; owner field is ID[MASTER_ID_WIDTH-1 -: PORT_BITS].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_msID  in  NUM_PORTS x MASTER_ID_WIDTH  per-port request ID
- s_msAddress  in  NUM_PORTS x ADDRESS_WIDTH  per-port address
- s_msData  in  NUM_PORTS x DATA_WIDTH  per-port write data
- s_msWrite  in  NUM_PORTS  1=write, 0=read
- s_msValid  in  NUM_PORTS  request valid
- s_msTaken  out  NUM_PORTS  request accepted this cycle
- s_smID  out  NUM_PORTS x MASTER_ID_WIDTH  response ID (broadcast)
- s_smData  out  NUM_PORTS x DATA_WIDTH  response data (broadcast)
- s_smValid  out  NUM_PORTS  response valid, owner port only
- s_smTaken  in  NUM_PORTS  response accepted by port
- m_msID/m_msAddress/m_msData/m_msWrite/m_msValid  out  as above  downstream request
- m_msTaken  in  1  downstream accepted request
- m_smID/m_smData/m_smValid  in  as above  downstream response
- m_smTaken  out  1  response consumed
- err_unrouted  out  1  sticky: response owner index >= NUM_PORTS
- err_underflow  out  1  sticky: response for port with zero outstanding

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, locked=0, grant=0, all counters=0, err flags=0.
  - All outputs derived from these: m_msValid=0, s_msTaken=0, s_smValid=0.
  - m_smTaken=0 unless m_smValid with an unrouted ID.
- Eligibility: port p is eligible if s_msValid[p] && !(s_msWrite[p]==0 && cnt[p]==MAX_OUTSTANDING). Writes are never throttled.
- Selection:
  - If locked, sel=grant.
  - Otherwise sel = the first eligible port searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Zero-cycle combinational path to the m_ms* outputs.
- m_msValid = eligible[sel]. m_ms* fields = port sel fields. s_msTaken[sel] = m_msTaken && m_msValid; all others 0.
- Lock: at posedge, if m_msValid && !m_msTaken then locked<=1, grant<=sel. If m_msValid && m_msTaken then locked<=0 and rr_ptr<=(sel+1) mod NUM_PORTS.
- Locked port deasserting s_msValid (protocol violation) drops m_msValid; locked clears the next cycle.
- Counters: cnt[p] increments on accepted read from p and decrements on accepted response to p. Both in the same cycle leave it unchanged.
  - Decrement at 0 holds 0 and sets err_underflow.
  - Increment never exceeds MAX_OUTSTANDING, because eligibility gates it.
- Response path (combinational):
  - owner = m_smID owner field.
  - If owner < NUM_PORTS: s_smValid[owner]=m_smValid and m_smTaken=s_smTaken[owner].
  - Otherwise m_smTaken=m_smValid (drop the response) and set err_unrouted.
  - s_smID/s_smData are broadcast to all ports.
- Request and response paths are independent. A simultaneous accept and response to the same port is legal.
- Error flags clear only on reset.

Decomposition:
- Shared package memory_bus_pkg: MASTER_ID_WIDTH/ADDRESS_WIDTH/DATA_WIDTH defaults, the owner-field extraction function, and a typedef for the request bundle struct (id, address, data, write).
- Sub-module rr_select: combinational rotate-priority picker (req vector, ptr -> index, any). Unit-tested separately.

Test Plan:
- Ports 0..3 all valid reads, m_msTaken=1 every cycle, rst_n released -> grants 0,1,2,3,0 on consecutive cycles; each s_msTaken pulses once per pass.
- Port 2 valid, m_msTaken=0 for 3 cycles, port 0 raised in cycle 1 -> m_msAddress holds port 2 value throughout; grant moves to port 0 the cycle after taken.
- Port 1 issues 4 reads (MAX_OUTSTANDING=4) with no responses -> 5th read blocked (m_msValid=0 if alone); one response with smID=8'h40 accepted -> cnt=3, next read granted.
- Response smID=8'h80 with s_smTaken[2]=0 for 2 cycles -> s_smValid[2]=1 only, m_smTaken=0 until port 2 takes.
- NUM_PORTS=3, response smID=8'hC0 -> m_smTaken=1 same cycle, no s_smValid asserted, err_unrouted=1 next cycle.
- rst_n asserted mid-lock with counters nonzero -> all state zero immediately; after release first grant comes from port 0.
